// File: rtl/bd_funnel_pkg.sv
// Shared types and the per-leaf route/serialization table for the BD funnel front end.
package bd_funnel_pkg;

  localparam int DEFAULT_LEAF_W    = 5;
  localparam int DEFAULT_PAYLOAD_W = 21;
  localparam int DEFAULT_OUT_W     = 21;
  localparam int CNT_W             = 5;
  localparam int N_LEAVES          = 6;

  typedef enum logic {IDLE, EMIT} fsm_state_e;

  typedef struct packed {
    logic [7:0]       route_code;  // right-aligned, route_len bits meaningful
    logic [CNT_W-1:0] route_len;
    logic [CNT_W-1:0] chunk_w;
    logic [CNT_W-1:0] n_chunks;
    logic             valid;
  } leaf_entry_t;

  typedef struct packed {
    logic [DEFAULT_LEAF_W-1:0]    leaf_code;
    logic [DEFAULT_PAYLOAD_W-1:0] payload;
  } UnencodedBDWord;

  localparam leaf_entry_t LEAF_TABLE [N_LEAVES] = '{
    '{8'h0A, 5'd4, 5'd17, 5'd1, 1'b1},
    '{8'h06, 5'd3, 5'd8,  5'd3, 1'b1},
    '{8'h01, 5'd2, 5'd11, 5'd2, 1'b1},
    '{8'h1D, 5'd5, 5'd16, 5'd2, 1'b1},
    '{8'h00, 5'd0, 5'd0,  5'd0, 1'b0},
    '{8'h00, 5'd1, 5'd7,  5'd3, 1'b1}
  };

  // Codes beyond the table return an all-zero (invalid) entry.
  function automatic leaf_entry_t leaf_lookup(input int code);
    leaf_entry_t e;
    e = '0;
    for (int i = 0; i < N_LEAVES; i++) begin
      if (code == i) e = LEAF_TABLE[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/bd_funnel_mux_encoder_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; pointer moves past the winner on advance.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [IDX_W-1:0] adv_idx,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     cand_oh;
  logic             found;
  int               cand;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = 0;
    cand_oh = '0;
    for (int off = 0; off < N; off++) begin
      cand    = (int'(ptr_q) + off) % N;
      cand_oh = N'(1) << cand;
      if (!found && |(req & cand_oh)) begin
        found = 1'b1;
        grant = cand_oh;
        idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (int'(adv_idx) == N - 1) ? '0 : adv_idx + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bd_funnel_mux_encoder.sv
// Multi-channel BD funnel front end: round-robin merge, per-leaf chunk serialization and route-code prefixing.
module bd_funnel_mux_encoder
  import bd_funnel_pkg::*;
#(
  parameter  int N_IN      = 2,
  parameter  int LEAF_W    = DEFAULT_LEAF_W,
  parameter  int PAYLOAD_W = DEFAULT_PAYLOAD_W,
  parameter  int OUT_W     = DEFAULT_OUT_W,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int WW        = LEAF_W + PAYLOAD_W,
  localparam int IDX_W     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_IN*WW-1:0]   in_d,
  input  logic [N_IN-1:0]      in_v,
  output logic [N_IN-1:0]      in_a,
  output logic [OUT_W-1:0]     out_d,
  output logic                 out_v,
  input  logic                 out_a,
  output logic                 err_bad_leaf,
  output logic [IDX_W-1:0]     grant_idx
);

  fsm_state_e             state_q, state_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [7:0]             route_q, route_d;
  logic [CNT_W-1:0]       rlen_q, rlen_d, cw_q, cw_d, n_chunks_q, n_chunks_d, cnt_q, cnt_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic                   err_q, err_d;

  logic [N_IN-1:0]        arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic [WW-1:0]          sel_word;
  leaf_entry_t            sel_ent;
  logic                   last_chunk, can_accept, accept;
  logic [CNT_W-1:0]       chunk_idx;
  logic [PAYLOAD_W-1:0]   shifted;
  logic [OUT_W-1:0]       chunk_mask, chunk, enc;

  rr_arbiter #(.N(N_IN)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (in_v),
    .advance (accept),
    .adv_idx (arb_idx),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  // A new word may enter when idle, or in the same cycle the last chunk is acked.
  always_comb begin
    sel_word   = in_d[int'(arb_idx)*WW +: WW];
    sel_ent    = leaf_lookup(int'(sel_word[WW-1 -: LEAF_W]));
    last_chunk = (cnt_q == n_chunks_q - CNT_W'(1));
    can_accept = (state_q == IDLE) || (out_a && last_chunk);
    in_a       = (reset && can_accept) ? arb_grant : '0;
    accept     = |in_a;
  end

  always_comb begin
    state_d    = state_q;
    payload_d  = payload_q;
    route_d    = route_q;
    rlen_d     = rlen_q;
    cw_d       = cw_q;
    n_chunks_d = n_chunks_q;
    cnt_d      = cnt_q;
    gidx_d     = gidx_q;
    err_d      = 1'b0;
    if (accept) begin
      payload_d  = sel_word[PAYLOAD_W-1:0];
      route_d    = sel_ent.route_code;
      rlen_d     = sel_ent.route_len;
      cw_d       = sel_ent.chunk_w;
      n_chunks_d = sel_ent.n_chunks;
      cnt_d      = '0;
      gidx_d     = arb_idx;
      err_d      = !sel_ent.valid;
      state_d    = sel_ent.valid ? EMIT : IDLE;
    end else if (state_q == EMIT && out_a) begin
      if (last_chunk) state_d = IDLE;
      else            cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Payload bits past PAYLOAD_W shift in as zero, so short final chunks are zero-filled.
  always_comb begin
    chunk_idx  = MSB_FIRST ? (n_chunks_q - CNT_W'(1) - cnt_q) : cnt_q;
    shifted    = payload_q >> (int'(chunk_idx) * int'(cw_q));
    chunk_mask = (OUT_W'(1) << cw_q) - OUT_W'(1);
    chunk      = OUT_W'(shifted) & chunk_mask;
    enc        = (OUT_W'(route_q) << (OUT_W - int'(rlen_q)))
               | (chunk << (OUT_W - int'(rlen_q) - int'(cw_q)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      payload_q  <= '0;
      route_q    <= '0;
      rlen_q     <= '0;
      cw_q       <= '0;
      n_chunks_q <= '0;
      cnt_q      <= '0;
      gidx_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      payload_q  <= payload_d;
      route_q    <= route_d;
      rlen_q     <= rlen_d;
      cw_q       <= cw_d;
      n_chunks_q <= n_chunks_d;
      cnt_q      <= cnt_d;
      gidx_q     <= gidx_d;
      err_q      <= err_d;
    end
  end

  assign out_v        = (state_q == EMIT);
  assign out_d        = out_v ? enc : '0;
  assign err_bad_leaf = err_q;
  assign grant_idx    = gidx_q;

endmodule

// File: tb/tb_bd_funnel_mux_encoder.sv
// Bench for bd_funnel_mux_encoder: queue-based reference model checked every cycle plus hand-computed pins.
module tb_bd_funnel_mux_encoder;
  import bd_funnel_pkg::*;

  localparam int N_IN = 2;
  localparam int LW   = 5;
  localparam int PW   = 21;
  localparam int OW   = 21;
  localparam int WW   = LW + PW;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [N_IN*WW-1:0] in_d = '0;
  logic [N_IN-1:0]   in_v  = '0;
  logic              out_a = 1'b0;
  logic [N_IN-1:0]   in_a, in_a_m;
  logic [OW-1:0]     out_d, out_d_m;
  logic              out_v, out_v_m, err, err_m;
  logic [0:0]        gidx, gidx_m;

  bd_funnel_mux_encoder #(.N_IN(N_IN), .MSB_FIRST(1'b0)) u_dut (
    .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a),
    .out_d(out_d), .out_v(out_v), .out_a(out_a), .err_bad_leaf(err), .grant_idx(gidx));

  bd_funnel_mux_encoder #(.N_IN(N_IN), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a_m),
    .out_d(out_d_m), .out_v(out_v_m), .out_a(out_a), .err_bad_leaf(err_m), .grant_idx(gidx_m));

  always #5 clk = ~clk;

  // Leaf table as the bench understands it: route, route length, chunk width, chunk count, mapped.
  int t_route [6] = '{10, 6, 1, 29, 0, 0};
  int t_len   [6] = '{4, 3, 2, 5, 0, 1};
  int t_cw    [6] = '{17, 8, 11, 16, 0, 7};
  int t_n     [6] = '{1, 3, 2, 2, 0, 3};
  bit t_ok    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int good_leaves [5] = '{0, 1, 2, 3, 5};

  typedef struct { logic [OW-1:0] lsb; logic [OW-1:0] msb; int ch; } exp_t;

  logic [WW-1:0] src_q [N_IN][$];
  exp_t          exp_q [$];
  logic [OW-1:0] log_lsb [$];
  logic [OW-1:0] log_msb [$];
  int            log_gnt [$];
  int            log_cyc [$];

  int n_checks, n_bad, cyc, err_seen, acc_cyc, ptr_m, out_mode;
  bit err_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] word_of(input int leaf, input longint chunk);
    longint w;
    w = longint'(t_route[leaf]) * (longint'(1) << (OW - t_len[leaf]))
      + chunk * (longint'(1) << (OW - t_len[leaf] - t_cw[leaf]));
    return OW'(w);
  endfunction

  function automatic void expand(input logic [WW-1:0] w, input int ch);
    int leaf;
    longint pay, modv;
    exp_t e;
    leaf = int'(w[WW-1 -: LW]);
    pay  = longint'(w[PW-1:0]);
    if (leaf >= 6 || !t_ok[leaf]) begin
      err_pend = 1'b1;
      return;
    end
    modv = longint'(1) << t_cw[leaf];
    for (int k = 0; k < t_n[leaf]; k++) begin
      e.lsb = word_of(leaf, (pay >> (k * t_cw[leaf])) % modv);
      e.msb = word_of(leaf, (pay >> ((t_n[leaf] - 1 - k) * t_cw[leaf])) % modv);
      e.ch  = ch;
      exp_q.push_back(e);
    end
  endfunction

  function automatic bit busy();
    bit b;
    b = (exp_q.size() != 0) || err_pend;
    for (int c = 0; c < N_IN; c++) if (src_q[c].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drive_inputs();
    for (int c = 0; c < N_IN; c++) begin
      in_v[c]          = (src_q[c].size() != 0);
      in_d[c*WW +: WW] = (src_q[c].size() != 0) ? src_q[c][0] : '0;
    end
    case (out_mode)
      0:       out_a = 1'b1;
      1:       out_a = 1'($urandom_range(0, 1));
      default: out_a = 1'b0;
    endcase
  endtask

  // Compare process: inputs change on the falling edge, outputs are checked 1 time unit later,
  // then the model advances as the coming rising edge will.
  int            m_pick;
  bit            m_ready;
  logic [N_IN-1:0] m_ea;
  logic [WW-1:0] m_w;

  always @(negedge clk) begin
    drive_inputs();
    #1;
    cyc++;
    if (err) err_seen++;
    if (!reset) begin
      check("rst_in_a", in_a, 0);
      check("rst_out_v", out_v, 0);
      check("rst_out_d", out_d, 0);
      check("rst_err", err, 0);
      check("rst_grant_idx", gidx, 0);
      exp_q.delete();
      ptr_m    = 0;
      err_pend = 1'b0;
    end else begin
      m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_a);
      m_pick  = -1;
      for (int off = 0; off < N_IN; off++)
        if (m_pick < 0 && in_v[(ptr_m + off) % N_IN]) m_pick = (ptr_m + off) % N_IN;
      m_ea = (m_ready && m_pick >= 0) ? (N_IN'(1) << m_pick) : '0;
      check("in_a", in_a, m_ea);
      check("in_a_msb", in_a_m, m_ea);
      check("out_v", out_v, exp_q.size() != 0);
      check("out_v_msb", out_v_m, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_d", out_d, exp_q[0].lsb);
        check("out_d_msb", out_d_m, exp_q[0].msb);
        check("grant_idx", gidx, exp_q[0].ch);
      end else begin
        check("idle_out_d", out_d, 0);
      end
      check("err_bad_leaf", err, err_pend);
      err_pend = 1'b0;
      if (exp_q.size() != 0 && out_a) begin
        log_lsb.push_back(out_d);
        log_msb.push_back(out_d_m);
        log_gnt.push_back(int'(gidx));
        log_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (m_ea != 0) begin
        m_w     = src_q[m_pick].pop_front();
        ptr_m   = (m_pick + 1) % N_IN;
        acc_cyc = cyc;
        expand(m_w, m_pick);
      end
    end
  end

  task automatic push(input int ch, input int leaf, input int pay);
    UnencodedBDWord w;
    w.leaf_code = LW'(leaf);
    w.payload   = PW'(pay);
    src_q[ch].push_back(w);
  endtask

  task automatic clear_logs();
    log_lsb.delete();
    log_msb.delete();
    log_gnt.delete();
    log_cyc.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", busy(), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, n_exp, leaf, waited;
    out_mode = 0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Single-chunk word held under backpressure, then released.
    clear_logs();
    @(posedge clk);
    out_mode = 2;
    push(0, 0, 'h1ABCD);
    repeat (4) @(posedge clk);
    #1;
    check("t1_hold_v", out_v, 1);
    check("t1_hold_d", out_d, 21'h15ABCD);
    check("t1_hold_in_a", in_a, 0);
    out_mode = 0;
    wait_drain(50);
    check("t1_count", log_lsb.size(), 1);
    if (log_lsb.size() == 1) check("t1_word", log_lsb[0], 21'h15ABCD);

    // Three-chunk word, back-to-back, both chunk orders.
    clear_logs();
    push(0, 1, 'h123456);
    wait_drain(50);
    check("t2_count", log_lsb.size(), 3);
    if (log_lsb.size() == 3) begin
      check("t2_lsb0", log_lsb[0], 21'h195800);
      check("t2_lsb1", log_lsb[1], 21'h18D000);
      check("t2_lsb2", log_lsb[2], 21'h184800);
      check("t2_msb0", log_msb[0], 21'h184800);
      check("t2_msb2", log_msb[2], 21'h195800);
      check("t2_latency", log_cyc[0], acc_cyc + 1);
      check("t2_contig", log_cyc[2], log_cyc[0] + 2);
    end

    // Both channels saturated with single-chunk words: pointer sits at 1 after two channel-0 words.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push(0, 0, i);
      push(1, 0, 16 + i);
    end
    wait_drain(100);
    check("t3_count", log_gnt.size(), 8);
    if (log_gnt.size() == 8) begin
      for (int i = 0; i < 8; i++) check("t3_grant", log_gnt[i], (i % 2 == 0) ? 1 : 0);
      check("t3_first", log_lsb[0], 21'h140010);
      check("t3_second", log_lsb[1], 21'h140000);
      check("t3_contig", log_cyc[7], log_cyc[0] + 7);
    end

    // Unmapped leaf code, then a normal word.
    clear_logs();
    e0 = err_seen;
    push(0, 31, 'h5);
    push(0, 0, 'h1);
    wait_drain(50);
    check("t4_err_pulses", err_seen - e0, 1);
    check("t4_count", log_lsb.size(), 1);
    if (log_lsb.size() == 1) check("t4_word", log_lsb[0], 21'h140001);

    // Leaf present in the table but marked invalid.
    clear_logs();
    e0 = err_seen;
    push(1, 4, 'h3);
    push(1, 0, 'h2);
    wait_drain(50);
    check("t5_err_pulses", err_seen - e0, 1);
    check("t5_count", log_lsb.size(), 1);
    if (log_lsb.size() == 1) check("t5_word", log_lsb[0], 21'h140002);

    // Random traffic under 50% output backpressure.
    clear_logs();
    n_exp    = 0;
    out_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      leaf = good_leaves[$urandom_range(0, 4)];
      push($urandom_range(0, N_IN - 1), leaf, int'($urandom_range(0, (1 << PW) - 1)));
      n_exp += t_n[leaf];
    end
    wait_drain(30000);
    check("t6_count", log_lsb.size(), n_exp);
    out_mode = 0;

    // Reset during the second chunk of a three-chunk word.
    push(0, 1, 'h123456);
    waited = 0;
    while (exp_q.size() != 2 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    check("t7_reached_chunk1", exp_q.size(), 2);
    push(1, 1, 'hAB);
    #2 reset = 1'b0;
    clear_logs();
    #1;
    check("t7_rst_out_v", out_v, 0);
    check("t7_rst_in_a", in_a, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    wait_drain(50);
    check("t7_count", log_lsb.size(), 3);
    if (log_lsb.size() == 3) begin
      check("t7_first", log_lsb[0], 21'h1AAC00);
      check("t7_second", log_lsb[1], 21'h180000);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
